// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM states, transaction
// lengths of the downstream SRAM interface and port indices.
package sram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int READ_CYCLES  = 5;
    localparam int WRITE_CYCLES = 6;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sram_arbiter_rr_pick2.sv
// Combinational two-way winner select: round-robin on last_grant, or
// fixed priority to port 0 when FIXED_PRI is set.
module rr_pick2
    import sram_arb_pkg::*;
#(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       req_any,
    output logic       winner
);

    always_comb begin
        req_any = |req;
        case (req)
            2'b11:   winner = FIXED_PRI ? PORT0 : ~last_grant;
            2'b10:   winner = PORT1;
            default: winner = PORT0;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one free-running single-transaction SRAM interface between an
// instruction-fetch port (0) and a data port (1), launching only on m_rdy.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_drw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_drw,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_drw,
    output logic [DATA_W-1:0] m_din,
    input  logic [DATA_W-1:0] m_dout,
    input  logic              m_rdy,
    output logic              busy,
    output logic              grant
);

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic              cmd_drw_q, cmd_drw_d;
    logic [DATA_W-1:0] cmd_din_q, cmd_din_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

    logic              complete;
    logic [1:0]        ack_vec;
    logic [1:0]        elig;
    logic              req_any;
    logic              winner;
    logic              launch;
    logic              win_drw;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // The in-flight transaction ends on the first boundary seen while BUSY.
    assign complete = (state_q == BUSY) && m_rdy;
    assign ack_vec  = !complete ? 2'b00 : ((grant_q == PORT1) ? 2'b10 : 2'b01);

    // The port being acked still holds req this cycle; it must not re-win.
    assign elig = {p1_req, p0_req} & ~ack_vec;

    rr_pick2 #(
        .FIXED_PRI (FIXED_PRI != 0)
    ) u_pick (
        .req        (elig),
        .last_grant (last_grant_q),
        .req_any    (req_any),
        .winner     (winner)
    );

    assign launch    = m_rdy && req_any;
    assign win_drw   = (winner == PORT1) ? p1_drw   : p0_drw;
    assign win_addr  = (winner == PORT1) ? p1_addr  : p0_addr;
    assign win_wdata = (winner == PORT1) ? p1_wdata : p0_wdata;

    // Anything that is not a live command is a harmless read of the last address.
    always_comb begin
        m_addr = cmd_addr_q;
        m_drw  = 1'b0;
        m_din  = '0;
        if (launch) begin
            m_addr = win_addr;
            m_drw  = win_drw;
            m_din  = win_wdata;
        end else if (state_q == BUSY && !m_rdy) begin
            m_addr = cmd_addr_q;
            m_drw  = cmd_drw_q;
            m_din  = cmd_din_q;
        end
    end

    // NOTE: every _d gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_drw_d    = cmd_drw_q;
        cmd_din_d    = cmd_din_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;

        if (complete && !cmd_drw_q) begin
            if (grant_q == PORT1) p1_rdata_d = m_dout;
            else                  p0_rdata_d = m_dout;
        end

        if (launch) begin
            state_d      = BUSY;
            grant_d      = winner;
            last_grant_d = winner;
            cmd_addr_d   = win_addr;
            cmd_drw_d    = win_drw;
            cmd_din_d    = win_wdata;
        end else if (complete) begin
            state_d = IDLE;
        end
    end

    // NOTE: reset is sampled on the clock edge only; a transaction caught in
    // flight is simply dropped, which is why the SRAM interface resets alongside.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= PORT0;
            last_grant_q <= PORT1;
            cmd_addr_q   <= '0;
            cmd_drw_q    <= 1'b0;
            cmd_din_q    <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_drw_q    <= cmd_drw_d;
            cmd_din_q    <= cmd_din_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    assign busy     = (state_q == BUSY);
    assign grant    = grant_q;
    assign p0_ack   = ack_vec[0];
    assign p1_ack   = ack_vec[1];
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: instance 0 is round-robin, instance 1 fixed priority, each
// in front of its own free-running SRAM interface model.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;

    logic        p0_req [2];
    logic        p0_drw [2];
    logic [31:0] p0_addr [2];
    logic [31:0] p0_wdata [2];
    logic        p0_ack [2];
    logic [31:0] p0_rdata [2];
    logic        p1_req [2];
    logic        p1_drw [2];
    logic [31:0] p1_addr [2];
    logic [31:0] p1_wdata [2];
    logic        p1_ack [2];
    logic [31:0] p1_rdata [2];
    logic [31:0] m_addr [2];
    logic        m_drw [2];
    logic [31:0] m_din [2];
    logic [31:0] m_dout [2];
    logic        m_rdy [2];
    logic        busy [2];
    logic        grant [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRI(0)) u_rr (
        .clk(clk), .rst(rst),
        .p0_req(p0_req[0]), .p0_drw(p0_drw[0]), .p0_addr(p0_addr[0]), .p0_wdata(p0_wdata[0]),
        .p0_ack(p0_ack[0]), .p0_rdata(p0_rdata[0]),
        .p1_req(p1_req[0]), .p1_drw(p1_drw[0]), .p1_addr(p1_addr[0]), .p1_wdata(p1_wdata[0]),
        .p1_ack(p1_ack[0]), .p1_rdata(p1_rdata[0]),
        .m_addr(m_addr[0]), .m_drw(m_drw[0]), .m_din(m_din[0]), .m_dout(m_dout[0]),
        .m_rdy(m_rdy[0]), .busy(busy[0]), .grant(grant[0])
    );

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRI(1)) u_fix (
        .clk(clk), .rst(rst),
        .p0_req(p0_req[1]), .p0_drw(p0_drw[1]), .p0_addr(p0_addr[1]), .p0_wdata(p0_wdata[1]),
        .p0_ack(p0_ack[1]), .p0_rdata(p0_rdata[1]),
        .p1_req(p1_req[1]), .p1_drw(p1_drw[1]), .p1_addr(p1_addr[1]), .p1_wdata(p1_wdata[1]),
        .p1_ack(p1_ack[1]), .p1_rdata(p1_rdata[1]),
        .m_addr(m_addr[1]), .m_drw(m_drw[1]), .m_din(m_din[1]), .m_dout(m_dout[1]),
        .m_rdy(m_rdy[1]), .busy(busy[1]), .grant(grant[1])
    );

    // ---------------- SRAM interface model ----------------
    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
    endfunction

    int          cnt [2];
    int          viol [2];
    logic        s_drw [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_din [2];
    logic        lat_drw [2];
    logic [31:0] lat_addr [2];
    logic [31:0] lat_din [2];

    assign m_rdy[0] = (cnt[0] == 0);
    assign m_rdy[1] = (cnt[1] == 0);

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            s_drw[k]  = m_drw[k];
            s_addr[k] = m_addr[k];
            s_din[k]  = m_din[k];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                cnt[k]    <= 0;
                m_dout[k] <= '0;
            end else if (cnt[k] == 0) begin
                lat_drw[k]  <= s_drw[k];
                lat_addr[k] <= s_addr[k];
                lat_din[k]  <= s_din[k];
                cnt[k]      <= (s_drw[k] ? WRITE_CYCLES : READ_CYCLES) - 1;
            end else begin
                if (s_drw[k] !== lat_drw[k] || s_addr[k] !== lat_addr[k] || s_din[k] !== lat_din[k])
                    viol[k] <= viol[k] + 1;
                if (cnt[k] == 1 && !lat_drw[k])
                    m_dout[k] <= rd_data(lat_addr[k]);
                cnt[k] <= cnt[k] - 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int k, input int p, input logic req, input logic drw,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            p0_req[k] = req; p0_drw[k] = drw; p0_addr[k] = addr; p0_wdata[k] = wdata;
        end else begin
            p1_req[k] = req; p1_drw[k] = drw; p1_addr[k] = addr; p1_wdata[k] = wdata;
        end
    endtask

    function automatic logic get_ack(input int k, input int p);
        return (p == 0) ? p0_ack[k] : p1_ack[k];
    endfunction

    function automatic logic [31:0] get_rdata(input int k, input int p);
        return (p == 0) ? p0_rdata[k] : p1_rdata[k];
    endfunction

    task automatic wait_ack(input int k, input int p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (get_ack(k, p)) ok = 1'b1;
        end
    endtask

    // Full transaction from one port: checks the launch command, the
    // m_rdy-to-ack latency and the single-cycle ack width.
    task automatic run_txn(input int k, input int p, input logic drw,
                           input logic [31:0] addr, input logic [31:0] wdata, input string name);
        bit found = 1'b0;
        int cyc = 0;
        int exp_lat = drw ? WRITE_CYCLES : READ_CYCLES;
        tick();
        set_port(k, p, 1'b1, drw, addr, wdata);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (m_rdy[k]) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL %s launch: no m_rdy boundary within 20 cycles", name);
        end else begin
            tests++;
            if (m_addr[k] !== addr || m_drw[k] !== drw || m_din[k] !== wdata) begin
                fails++;
                $display("FAIL %s cmd: got addr=%h drw=%b din=%h expected addr=%h drw=%b din=%h",
                         name, m_addr[k], m_drw[k], m_din[k], addr, drw, wdata);
            end
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                cyc++;
                if (get_ack(k, p)) found = 1'b1;
            end
            tests++;
            if (!found || cyc != exp_lat) begin
                fails++;
                $display("FAIL %s latency: got %0d cycles (ack seen=%0d) expected %0d",
                         name, cyc, found, exp_lat);
            end
        end
        tick();
        set_port(k, p, 1'b0, drw, addr, wdata);
        @(negedge clk);
        tests++;
        if (get_ack(k, p) !== 1'b0) begin
            fails++;
            $display("FAIL %s ack width: got ack=%b one cycle after ack expected 0", name, get_ack(k, p));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_port(k, 0, 1'b0, 1'b0, 32'h0, 32'h0);
            set_port(k, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (busy[k] !== 1'b0 || grant[k] !== 1'b0) begin
                fails++;
                $display("FAIL reset state[%0d]: got busy=%b grant=%b expected 0 0", k, busy[k], grant[k]);
            end
            tests++;
            if (p0_ack[k] !== 1'b0 || p1_ack[k] !== 1'b0 || p0_rdata[k] !== 32'h0 || p1_rdata[k] !== 32'h0) begin
                fails++;
                $display("FAIL reset ports[%0d]: got acks=%b%b rdata=%h/%h expected 00 and 0/0",
                         k, p0_ack[k], p1_ack[k], p0_rdata[k], p1_rdata[k]);
            end
            tests++;
            if (m_drw[k] !== 1'b0 || m_addr[k] !== 32'h0 || m_din[k] !== 32'h0) begin
                fails++;
                $display("FAIL reset cmd[%0d]: got drw=%b addr=%h din=%h expected dummy read at 0",
                         k, m_drw[k], m_addr[k], m_din[k]);
            end
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        run_txn(0, 0, 1'b0, 32'h100, 32'h0, "single_read");
        tests++;
        if (p0_rdata[0] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL single_read data: got %h expected deadbeef", p0_rdata[0]);
        end
    endtask

    task automatic test_single_write();
        run_txn(0, 1, 1'b1, 32'h200, 32'h12345678, "single_write");
        tests++;
        if (p1_rdata[0] !== 32'h0) begin
            fails++;
            $display("FAIL single_write rdata: got %h expected unchanged 00000000", p1_rdata[0]);
        end
    endtask

    task automatic test_round_robin();
        int  exp_port [4] = '{0, 1, 0, 1};
        int  n_ack = 0;
        int  idle = 0;
        int  got;
        bit  started = 1'b0;
        bit  ok;
        tick();
        set_port(0, 0, 1'b1, 1'b0, 32'h300, 32'h0);
        set_port(0, 1, 1'b1, 1'b1, 32'h400, 32'hA0A0A0A0);
        for (int cyc = 0; cyc < 100 && n_ack < 4; cyc++) begin
            @(negedge clk);
            if (started && !busy[0]) idle++;
            if (!started && m_rdy[0]) started = 1'b1;
            if (p0_ack[0] || p1_ack[0]) begin
                got = p1_ack[0] ? 1 : 0;
                tests++;
                if (got != exp_port[n_ack]) begin
                    fails++;
                    $display("FAIL rr order #%0d: got port %0d expected port %0d", n_ack, got, exp_port[n_ack]);
                end
                n_ack++;
            end
        end
        tests++;
        if (n_ack != 4) begin
            fails++;
            $display("FAIL rr count: got %0d acks expected 4", n_ack);
        end
        tests++;
        if (idle != 0) begin
            fails++;
            $display("FAIL rr bubbles: got %0d idle cycles expected 0", idle);
        end
        tick();
        set_port(0, 1, 1'b0, 1'b1, 32'h400, 32'hA0A0A0A0);
        wait_ack(0, 0, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rr drain: got no p0 ack expected one within 30 cycles");
        end
        tick();
        set_port(0, 0, 1'b0, 1'b0, 32'h300, 32'h0);
        @(negedge clk);
        tests++;
        if (p0_rdata[0] !== rd_data(32'h300) || p1_rdata[0] !== 32'h0) begin
            fails++;
            $display("FAIL rr rdata: got %h/%h expected %h/00000000", p0_rdata[0], p1_rdata[0], rd_data(32'h300));
        end
    endtask

    // After a lone port-0 read, a tie goes to port 1 under round-robin and
    // to port 0 under fixed priority; the loser follows without a bubble.
    task automatic test_tie(input int k, input int exp_first, input string name);
        int  got = -1;
        int  other;
        bit  ok = 1'b0;
        run_txn(k, 0, 1'b0, 32'h700, 32'h0, name);
        tick();
        set_port(k, 0, 1'b1, 1'b0, 32'h710, 32'h0);
        set_port(k, 1, 1'b1, 1'b0, 32'h720, 32'h0);
        for (int i = 0; i < 30 && got < 0; i++) begin
            @(negedge clk);
            if (p0_ack[k]) got = 0;
            else if (p1_ack[k]) got = 1;
        end
        tests++;
        if (got != exp_first) begin
            fails++;
            $display("FAIL %s first: got port %0d expected port %0d", name, got, exp_first);
        end
        other = (got == 1) ? 0 : 1;
        tick();
        set_port(k, 1 - other, 1'b0, 1'b0, (other == 0) ? 32'h720 : 32'h710, 32'h0);
        wait_ack(k, other, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s second: got no ack on port %0d expected one", name, other);
        end
        tick();
        set_port(k, other, 1'b0, 1'b0, (other == 0) ? 32'h710 : 32'h720, 32'h0);
        @(negedge clk);
        tests++;
        if (get_rdata(k, 0) !== rd_data(32'h710) || get_rdata(k, 1) !== rd_data(32'h720)) begin
            fails++;
            $display("FAIL %s rdata: got %h/%h expected %h/%h", name, get_rdata(k, 0), get_rdata(k, 1),
                     rd_data(32'h710), rd_data(32'h720));
        end
    endtask

    task automatic test_mid_request();
        bit          found = 1'b0;
        bit          ok;
        int          bad = 0;
        logic [31:0] a0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (m_rdy[0]) found = 1'b1;
        end
        a0 = m_addr[0];
        tick();
        set_port(0, 0, 1'b1, 1'b1, 32'h500, 32'h55AA55AA);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (m_rdy[0]) found = 1'b1;
            else if (m_drw[0] !== 1'b0 || m_addr[0] !== a0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL mid_req hold: got %0d cycles with changed command expected 0", bad);
        end
        tests++;
        if (!found || m_drw[0] !== 1'b1 || m_addr[0] !== 32'h500) begin
            fails++;
            $display("FAIL mid_req launch: got boundary=%0d drw=%b addr=%h expected 1 1 00000500",
                     found, m_drw[0], m_addr[0]);
        end
        wait_ack(0, 0, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL mid_req ack: got no ack expected one within 30 cycles");
        end
        tick();
        set_port(0, 0, 1'b0, 1'b1, 32'h500, 32'h55AA55AA);
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        tick();
        set_port(0, 1, 1'b1, 1'b1, 32'h600, 32'h0BADF00D);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (m_rdy[0]) found = 1'b1;
        end
        repeat (2) @(negedge clk);
        tests++;
        if (busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid busy: got %b expected 1 before reset", busy[0]);
        end
        tick();
        rst = 1'b0;
        set_port(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy[0] !== 1'b0 || p0_ack[0] !== 1'b0 || p1_ack[0] !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid state: got busy=%b acks=%b%b expected 0 00", busy[0], p0_ack[0], p1_ack[0]);
        end
        tests++;
        if (p0_rdata[0] !== 32'h0 || p1_rdata[0] !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid rdata: got %h/%h expected 0/0", p0_rdata[0], p1_rdata[0]);
        end
        tests++;
        if (m_drw[0] !== 1'b0 || m_din[0] !== 32'h0 || m_addr[0] !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid cmd: got drw=%b addr=%h din=%h expected dummy read at 0",
                     m_drw[0], m_addr[0], m_din[0]);
        end
        tick();
        rst = 1'b1;
        run_txn(0, 0, 1'b0, 32'h100, 32'h0, "post_reset_read");
        tests++;
        if (p0_rdata[0] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL post_reset_read data: got %h expected deadbeef", p0_rdata[0]);
        end
    endtask

    task automatic test_stability();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (viol[k] != 0) begin
                fails++;
                $display("FAIL stability[%0d]: got %0d mid-transaction command changes expected 0", k, viol[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_tie(0, 1, "tie_rr");
        test_tie(1, 0, "tie_fixed");
        test_mid_request();
        test_reset_mid();
        test_stability();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
